// File: rtl/adiabatic_phase_sequencer.sv
// Issue controller for the 16-bit adiabatic AND datapath.
// Generates the four power-clock phase enables, hands operands to the datapath
// once per power-clock period, captures results into a small FIFO, and parks
// the power clocks after a run of empty periods.
module adiabatic_phase_sequencer #(
   parameter int WIDTH        = 16,
   parameter int QTR_CYCLES   = 4,
   parameter int PIPE_DEPTH   = 1,
   parameter int FIFO_DEPTH   = 2,
   parameter int IDLE_PERIODS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   input  logic [WIDTH-1:0] res_i,
   output logic             clkpos,
   output logic             clkpos2,
   output logic             clkneg,
   output logic             clkneg2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int QW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = $clog2(IDLE_PERIODS + 1);
   localparam int SW = $clog2(PIPE_DEPTH + FIFO_DEPTH + 1);

   typedef enum logic {STOPPED, RUN} state_t;

   state_t                state, state_n;
   logic [1:0]            q, q_n;
   logic [QW-1:0]         qcnt, qcnt_n;
   logic [IW-1:0]         idle_cnt, idle_n;
   // one valid bit per datapath stage; bit PIPE_DEPTH-1 is the stage whose
   // result is captured in the current period
   logic [PIPE_DEPTH-1:0] vld_p;
   logic [WIDTH-1:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr, wr_ptr;
   logic [CW-1:0]         fifo_cnt;
   logic [SW-1:0]         occ;
   logic                  credit, bnd, accept, push, pop, run_n;

   // Occupancy seen by the credit check: ops in the datapath plus buffered results
   always_comb begin
      occ = SW'(fifo_cnt);
      for (int i = 0; i < PIPE_DEPTH; i++) occ = occ + SW'(vld_p[i]);
   end

   assign credit    = occ < SW'(FIFO_DEPTH);
   assign bnd       = (state == RUN) && (q == 2'd3) && (qcnt == QW'(QTR_CYCLES - 1));
   assign in_ready  = credit && ((state == STOPPED) || bnd);
   assign accept    = in_valid && in_ready;
   // the oldest op's result is stable by the end of quarter 2 of its final period
   assign push      = (state == RUN) && vld_p[PIPE_DEPTH-1] && (q == 2'd2) &&
                      (qcnt == QW'(QTR_CYCLES - 1));
   assign out_valid = (fifo_cnt != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = mem[rd_ptr];
   assign busy      = (state == RUN);
   assign run_n     = (state_n == RUN);

   // Next-state for the sequencer FSM, quarter timing and idle counting
   always_comb begin
      state_n = state;
      q_n     = q;
      qcnt_n  = qcnt;
      idle_n  = idle_cnt;
      case (state)
         STOPPED: begin
            if (accept) begin
               state_n = RUN;
               q_n     = 2'd0;
               qcnt_n  = '0;
               idle_n  = '0;
            end
         end
         RUN: begin
            if (qcnt == QW'(QTR_CYCLES - 1)) begin
               qcnt_n = '0;
               q_n    = q + 2'd1;
            end else begin
               qcnt_n = qcnt + QW'(1);
            end
            if (bnd) begin
               if (accept) begin
                  idle_n = '0;
               end else if (vld_p == '0) begin
                  idle_n = idle_cnt + IW'(1);
                  if (idle_n == IW'(IDLE_PERIODS)) begin
                     // park only at a period boundary; timing restarts at q=0
                     state_n = STOPPED;
                     q_n     = 2'd0;
                     qcnt_n  = '0;
                  end
               end
            end
         end
         default: state_n = STOPPED;
      endcase
   end

   // Sequencer registers: FSM, operand hold, in-flight bits, glitch-free phase enables
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= STOPPED;
         q        <= 2'd0;
         qcnt     <= '0;
         idle_cnt <= '0;
         vld_p    <= '0;
         a_o      <= '0;
         b_o      <= '0;
         clkpos   <= 1'b0;
         clkpos2  <= 1'b0;
         clkneg   <= 1'b1;
         clkneg2  <= 1'b1;
      end else begin
         state    <= state_n;
         q        <= q_n;
         qcnt     <= qcnt_n;
         idle_cnt <= idle_n;
         if (accept && (state == STOPPED)) begin
            vld_p <= PIPE_DEPTH'(1);
         end else if (bnd) begin
            vld_p <= (vld_p << 1) | PIPE_DEPTH'(accept);
         end
         if (accept) begin
            a_o <= in_a;
            b_o <= in_b;
         end else if (bnd) begin
            a_o <= '0;
            b_o <= '0;
         end
         // enables derive from next-cycle quarter so they change only on clk edges
         clkpos  <= run_n && !q_n[1];
         clkpos2 <= run_n && (q_n[1] ^ q_n[0]);
         clkneg  <= !(run_n && !q_n[1]);
         clkneg2 <= !(run_n && (q_n[1] ^ q_n[0]));
      end
   end

   // Result FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Result storage; contents are only meaningful where the occupancy says so
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= res_i;
   end

endmodule

// File: tb/tb_adiabatic_phase_sequencer.sv
// Bench for adiabatic_phase_sequencer: directed scenarios plus random traffic,
// every output compared each cycle against a timestamp-based reference model.
module tb_adiabatic_phase_sequencer;

   localparam int W    = 16;
   localparam int Q    = 4;
   localparam int D    = 1;
   localparam int FD   = 2;
   localparam int IDLE = 2;
   localparam int P    = 4 * Q;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, busy;
   logic [W-1:0]  in_a, in_b, a_o, b_o, res_i, out_data;
   logic          clkpos, clkpos2, clkneg, clkneg2;

   int errors = 0;
   int checks = 0;

   // datapath stand-in: combinational AND of the held operands
   assign res_i = a_o & b_o;

   always #5 clk = ~clk;

   adiabatic_phase_sequencer #(
      .WIDTH(W), .QTR_CYCLES(Q), .PIPE_DEPTH(D), .FIFO_DEPTH(FD), .IDLE_PERIODS(IDLE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .a_o(a_o), .b_o(b_o), .res_i(res_i),
      .clkpos(clkpos), .clkpos2(clkpos2), .clkneg(clkneg), .clkneg2(clkneg2),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   // reference model: ops are timestamped with their accept cycle and all
   // timing follows from the period arithmetic
   typedef struct {
      int        acc;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   op_t          ops[$];
   logic [W-1:0] fq[$];
   int           cyc, pos, idle;
   bit           running;
   logic [W-1:0] cur_a, cur_b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int n_inflight();
      int n = 0;
      foreach (ops[i]) if (cyc >= ops[i].acc + 1 && cyc <= ops[i].acc + D * P) n++;
      return n;
   endfunction

   function automatic bit exp_ready();
      bit cr = (n_inflight() + fq.size()) < FD;
      return cr && (!running || pos == P - 1);
   endfunction

   task automatic model_reset();
      ops.delete();
      fq.delete();
      pos = 0; idle = 0; running = 0;
      cur_a = '0; cur_b = '0;
   endtask

   task automatic model_update();
      bit   bnd, acc, pushed;
      int   ninfl;
      logic [W-1:0] pv;
      op_t  keep[$];
      bnd    = running && (pos == P - 1);
      ninfl  = n_inflight();
      acc    = in_valid && exp_ready();
      pushed = 0;
      pv     = '0;
      foreach (ops[i]) if (cyc == ops[i].acc + (D - 1) * P + 3 * Q) begin
         pushed = 1;
         pv     = ops[i].a & ops[i].b;
      end
      if (fq.size() > 0 && out_ready) void'(fq.pop_front());
      if (pushed) fq.push_back(pv);
      foreach (ops[i]) if (cyc < ops[i].acc + D * P) keep.push_back(ops[i]);
      ops = keep;
      if (acc) ops.push_back('{acc: cyc, a: in_a, b: in_b});
      if (!running) begin
         if (acc) begin
            running = 1; pos = 0; idle = 0; cur_a = in_a; cur_b = in_b;
         end
      end else begin
         pos = (pos + 1) % P;
         if (bnd) begin
            if (acc) begin
               idle = 0; cur_a = in_a; cur_b = in_b;
            end else begin
               cur_a = '0; cur_b = '0;
               if (ninfl == 0) begin
                  idle++;
                  if (idle == IDLE) begin
                     running = 0; pos = 0;
                  end
               end
            end
         end
      end
      cyc++;
   endtask

   // compare every output against the model, advance the model, move to next negedge
   task automatic step();
      bit cp  = running && (pos < 2 * Q);
      bit cp2 = running && (pos >= Q) && (pos < 3 * Q);
      check("busy",      32'(busy),      32'(running));
      check("clkpos",    32'(clkpos),    32'(cp));
      check("clkpos2",   32'(clkpos2),   32'(cp2));
      check("clkneg",    32'(clkneg),    32'(!cp));
      check("clkneg2",   32'(clkneg2),   32'(!cp2));
      check("a_o",       32'(a_o),       32'(cur_a));
      check("b_o",       32'(b_o),       32'(cur_b));
      check("out_valid", 32'(out_valid), 32'(fq.size() > 0));
      check("in_ready",  32'(in_ready),  32'(exp_ready()));
      if (fq.size() > 0) check("out_data", 32'(out_data), 32'(fq[0]));
      model_update();
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_clkpos"},    32'(clkpos),    32'd0);
      check({tag, "_clkpos2"},   32'(clkpos2),   32'd0);
      check({tag, "_clkneg"},    32'(clkneg),    32'd1);
      check({tag, "_clkneg2"},   32'(clkneg2),   32'd1);
      check({tag, "_a_o"},       32'(a_o),       32'd0);
      check({tag, "_b_o"},       32'(b_o),       32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      cyc = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check_reset_values("rst");
      rst_n = 1'b1;

      // single op from STOPPED, result exactly 13 cycles after accept
      in_valid = 1'b1; in_a = 16'hF0F0; in_b = 16'hFF00; out_ready = 1'b1;
      check("t1_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("t1_busy_next", 32'(busy), 32'd1);
      for (int i = 0; i < 11; i++) step();
      check("t1_not_early", 32'(out_valid), 32'd0);
      step();
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_data", 32'(out_data), 32'h0000F000);
      for (int i = 0; i < 40; i++) step();

      // back-to-back offers with a free-running consumer
      in_valid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         in_a = W'($urandom); in_b = W'($urandom);
         step();
      end

      // stalled consumer: credit limits acceptance to the FIFO depth
      out_ready = 1'b0;
      for (int i = 0; i < 80; i++) begin
         in_a = W'($urandom); in_b = W'($urandom);
         step();
      end
      check("t3_full", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 40; i++) step();
      out_ready = 1'b1;
      in_valid = 1'b0;

      // idle run: clocks park after empty periods, then restart at q=0
      for (int i = 0; i < 70; i++) step();
      check("t4_parked_busy", 32'(busy), 32'd0);
      check("t4_parked_neg", 32'({clkneg, clkneg2}), 32'd3);
      in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0FF0;
      step();
      in_valid = 1'b0;
      check("t4_restart_q0", 32'({clkpos, clkpos2}), 32'd2);

      // asynchronous reset during quarter 1 with the op in flight
      for (int i = 0; i < 5; i++) step();
      #2 rst_n = 1'b0;
      #1 check_reset_values("t5");
      model_reset();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) step();
      check("t5_no_result", 32'(out_valid), 32'd0);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_a = W'($urandom); in_b = W'($urandom);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 60; i++) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
